// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one down-counting delay timer among NUM_REQ requesters
module timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] count_i,
    input  logic                     cancel_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     busy_o,
    output logic [IDXW-1:0]          owner_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] cnt;
    logic [IDXW-1:0] ptr, win;
    logic any_req, grant, expire;
    logic [NUM_REQ-1:0] ack_nx, done_nx;

    function automatic logic [IDXW-1:0] wrap(input int v);
        return IDXW'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction

    // ptr holds the first index to search; descending loop leaves the nearest requester in win
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_i[wrap(int'(ptr) + i)]) win = wrap(int'(ptr) + i);
    end

    assign any_req = |req_i;
    assign grant   = (state == IDLE) && any_req;
    assign expire  = (state == RUN) && !cancel_i && (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (any_req ? RUN : IDLE)
                                   : ((cancel_i || cnt == '0) ? IDLE : RUN);

    always_comb begin
        ack_nx  = '0;
        done_nx = '0;
        if (grant) ack_nx[win] = 1'b1;
        if (expire) done_nx[owner_o] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            cnt     <= '0;
            ptr     <= '0;
            owner_o <= '0;
            ack_o   <= '0;
            done_o  <= '0;
        end else begin
            ack_o  <= ack_nx;
            done_o <= done_nx;
            if (grant) begin
                cnt     <= count_i[win*WIDTH +: WIDTH];
                owner_o <= win;
                ptr     <= (win == IDXW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end else if (state == RUN) begin
                cnt <= cancel_i ? '0 : ((cnt != '0) ? cnt - 1'b1 : cnt);
            end
        end

    assign busy_o = (state == RUN);
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed scenario tests for timer_arbiter
module tb_timer_arbiter;
    logic        clk_i = 0;
    logic        rst_ni = 0;
    logic [3:0]  req_i = '0;
    logic [31:0] count_i = '0;
    logic        cancel_i = 0;
    logic [3:0]  ack_o, done_o;
    logic        busy_o;
    logic [1:0]  owner_o;
    int checks = 0;
    int errors = 0;

    timer_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .count_i(count_i),
        .cancel_i(cancel_i), .ack_o(ack_o), .done_o(done_o),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        tick();
        rst_ni = 1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({ack_o, done_o, busy_o, owner_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {ack_o, done_o, busy_o, owner_o});
        end
        rst_ni = 1;
        tick();
        checks++;
        if ({ack_o, done_o, busy_o} !== 9'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %b expected 0", {ack_o, done_o, busy_o});
        end
    endtask

    task automatic test_single();
        count_i[8 +: 8] = 8'd5;
        req_i = 4'b0010;
        tick();
        checks++;
        if (ack_o !== 4'b0010 || busy_o !== 1'b1 || owner_o !== 2'd1 || done_o !== 4'b0) begin
            errors++;
            $display("FAIL single_ack ack=%b busy=%b owner=%0d done=%b expected 0010 1 1 0000", ack_o, busy_o, owner_o, done_o);
        end
        req_i = 4'b0;
        count_i[8 +: 8] = 8'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ack_o !== 4'b0 || done_o !== 4'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_run%0d ack=%b done=%b busy=%b expected 0000 0000 1", i, ack_o, done_o, busy_o);
            end
        end
        tick();
        checks++;
        if (done_o !== 4'b0010 || busy_o !== 1'b0 || owner_o !== 2'd1) begin
            errors++;
            $display("FAIL single_done done=%b busy=%b owner=%0d expected 0010 0 1", done_o, busy_o, owner_o);
        end
        tick();
        checks++;
        if (done_o !== 4'b0 || ack_o !== 4'b0 || owner_o !== 2'd1) begin
            errors++;
            $display("FAIL single_after done=%b ack=%b owner=%0d expected 0000 0000 1", done_o, ack_o, owner_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        count_i[0 +: 8]  = 8'd3;
        count_i[16 +: 8] = 8'd3;
        req_i = 4'b0101;
        tick();
        checks++;
        if (ack_o !== 4'b0001 || owner_o !== 2'd0) begin
            errors++;
            $display("FAIL b2b_ack0 ack=%b owner=%0d expected 0001 0", ack_o, owner_o);
        end
        req_i = 4'b0100;
        tick(); tick(); tick();
        checks++;
        if (busy_o !== 1'b1 || done_o !== 4'b0 || ack_o !== 4'b0) begin
            errors++;
            $display("FAIL b2b_run0 busy=%b done=%b ack=%b expected 1 0000 0000", busy_o, done_o, ack_o);
        end
        tick();
        checks++;
        if (done_o !== 4'b0001 || busy_o !== 1'b0 || ack_o !== 4'b0) begin
            errors++;
            $display("FAIL b2b_done0 done=%b busy=%b ack=%b expected 0001 0 0000", done_o, busy_o, ack_o);
        end
        tick();
        checks++;
        if (ack_o !== 4'b0100 || owner_o !== 2'd2 || done_o !== 4'b0) begin
            errors++;
            $display("FAIL b2b_ack2 ack=%b owner=%0d done=%b expected 0100 2 0000", ack_o, owner_o, done_o);
        end
        req_i = 4'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (done_o !== 4'b0100 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done2 done=%b busy=%b expected 0100 0", done_o, busy_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        count_i = '0;
        req_i = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            exp = 4'b0001 << (g % 4);
            tick();
            checks++;
            if (ack_o !== exp || done_o !== 4'b0 || owner_o !== 2'(g % 4)) begin
                errors++;
                $display("FAIL rr_ack%0d ack=%b done=%b owner=%0d expected %b 0000 %0d", g, ack_o, done_o, owner_o, exp, g % 4);
            end
            if (g == 5) req_i = 4'b0;
            tick();
            checks++;
            if (done_o !== exp || ack_o !== 4'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rr_done%0d done=%b ack=%b busy=%b expected %b 0000 0", g, done_o, ack_o, busy_o, exp);
            end
        end
        tick();
    endtask

    task automatic test_cancel();
        int bad = 0;
        count_i[24 +: 8] = 8'd6;
        req_i = 4'b1000;
        tick();
        checks++;
        if (ack_o !== 4'b1000 || owner_o !== 2'd3) begin
            errors++;
            $display("FAIL cancel_ack3 ack=%b owner=%0d expected 1000 3", ack_o, owner_o);
        end
        count_i[0 +: 8] = 8'd2;
        req_i = 4'b0001;
        tick();
        tick();
        cancel_i = 1;
        tick();
        cancel_i = 0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 4'b0 || ack_o !== 4'b0) begin
            errors++;
            $display("FAIL cancel_stop busy=%b done=%b ack=%b expected 0 0000 0000", busy_o, done_o, ack_o);
        end
        tick();
        checks++;
        if (ack_o !== 4'b0001 || owner_o !== 2'd0 || done_o !== 4'b0) begin
            errors++;
            $display("FAIL cancel_regrant ack=%b owner=%0d done=%b expected 0001 0 0000", ack_o, owner_o, done_o);
        end
        req_i = 4'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done_o !== 4'b0) bad++;
        end
        tick();
        checks++;
        if (done_o !== 4'b0001 || bad != 0) begin
            errors++;
            $display("FAIL cancel_next_done done=%b early=%0d expected 0001 0", done_o, bad);
        end
        tick();
    endtask

    task automatic test_cancel_zero();
        count_i[16 +: 8] = 8'd1;
        req_i = 4'b0100;
        tick();
        req_i = 4'b0;
        tick();
        cancel_i = 1;
        tick();
        cancel_i = 0;
        checks++;
        if (done_o !== 4'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_zero done=%b busy=%b expected 0000 0", done_o, busy_o);
        end
        tick();
        checks++;
        if (done_o !== 4'b0 || ack_o !== 4'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_zero_after done=%b ack=%b busy=%b expected 0000 0000 0", done_o, ack_o, busy_o);
        end
        count_i[8 +: 8] = 8'd0;
        cancel_i = 1;
        req_i = 4'b0010;
        tick();
        cancel_i = 0;
        req_i = 4'b0;
        checks++;
        if (ack_o !== 4'b0010 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL cancel_idle_ignored ack=%b busy=%b expected 0010 1", ack_o, busy_o);
        end
        tick();
        checks++;
        if (done_o !== 4'b0010 || ack_o !== 4'b0) begin
            errors++;
            $display("FAIL n0_done done=%b ack=%b expected 0010 0000", done_o, ack_o);
        end
        tick();
    endtask

    task automatic test_max_count();
        int bad = 0;
        count_i[8 +: 8] = 8'd255;
        req_i = 4'b0010;
        tick();
        req_i = 4'b0;
        checks++;
        if (ack_o !== 4'b0010) begin
            errors++;
            $display("FAIL max_ack ack=%b expected 0010", ack_o);
        end
        for (int i = 0; i < 255; i++) begin
            tick();
            if (done_o !== 4'b0 || busy_o !== 1'b1) bad++;
        end
        tick();
        checks++;
        if (done_o !== 4'b0010 || busy_o !== 1'b0 || bad != 0) begin
            errors++;
            $display("FAIL max_done done=%b busy=%b early=%0d expected 0010 0 0", done_o, busy_o, bad);
        end
        tick();
    endtask

    task automatic test_async_reset();
        count_i[24 +: 8] = 8'd200;
        req_i = 4'b1000;
        tick();
        req_i = 4'b0;
        for (int i = 0; i < 100; i++) tick();
        #2;
        rst_ni = 0;
        #1;
        checks++;
        if ({ack_o, done_o, busy_o, owner_o} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got %b expected 0", {ack_o, done_o, busy_o, owner_o});
        end
        tick();
        rst_ni = 1;
        req_i = 4'b1001;
        tick();
        req_i = 4'b0;
        checks++;
        if (ack_o !== 4'b0001 || owner_o !== 2'd0) begin
            errors++;
            $display("FAIL ptr_reset ack=%b owner=%0d expected 0001 0", ack_o, owner_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_cancel();
        test_cancel_zero();
        test_max_count();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
